// File: rtl/tile_pkg.sv
// Shared types for the tile MAC engine: operation codes, FSM states and the
// accumulator-to-output range classification used for saturation and overflow.
package tile_pkg;

  typedef enum logic [1:0] {
    OP_MUL = 2'd0,
    OP_ADD = 2'd1,
    OP_SUB = 2'd2,
    OP_HAD = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    RNG_IN,
    RNG_ABOVE,
    RNG_BELOW
  } range_e;

  // Classifies acc against the signed data_w range; anything but RNG_IN is an
  // overflow, and the caller clamps or truncates depending on sat_mode.
  function automatic range_e sat_conv(input longint acc, input int data_w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (data_w - 1)) - 1;
    lo = -hi - 1;
    if (acc > hi) return RNG_ABOVE;
    if (acc < lo) return RNG_BELOW;
    return RNG_IN;
  endfunction

endpackage

// File: rtl/tile_mac_unit.sv
// Datapath of the tile engine: operand-valid pipeline flag, multiply/add/sub,
// the wide accumulator, output conversion and the sticky overflow flag.
module tile_mac_unit
  import tile_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic              clear,
  input  logic              abort,
  input  logic              wr_en,
  input  logic              ovf_clear,
  input  op_e               op,
  input  logic              sat,
  input  logic [DATA_W-1:0] a_dout,
  input  logic [DATA_W-1:0] b_dout,
  output logic [DATA_W-1:0] c_dout,
  output logic              ovf
);

  logic                     valid_q, valid_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     ovf_q, ovf_d;

  logic signed [DATA_W-1:0]   a_s, b_s;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    a_x, b_x, prod_x;
  range_e                     range;

  assign a_s    = a_dout;
  assign b_s    = b_dout;
  assign prod   = a_s * b_s;
  assign a_x    = {{(ACC_W-DATA_W){a_s[DATA_W-1]}}, a_s};
  assign b_x    = {{(ACC_W-DATA_W){b_s[DATA_W-1]}}, b_s};
  assign prod_x = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign range  = sat_conv(longint'(acc_q), DATA_W);

  always_comb begin
    valid_d = issue;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    if (valid_q) begin
      case (op)
        OP_ADD:  acc_d = a_x + b_x;
        OP_SUB:  acc_d = a_x - b_x;
        default: acc_d = acc_q + prod_x;
      endcase
    end
    if (clear) acc_d = '0;
    if (ovf_clear) ovf_d = 1'b0;
    else if (wr_en && range != RNG_IN) ovf_d = 1'b1;
    if (abort) begin
      valid_d = 1'b0;
      acc_d   = '0;
    end
  end

  always_comb begin
    c_dout = acc_q[DATA_W-1:0];
    if (sat && range == RNG_ABOVE) c_dout = {1'b0, {(DATA_W-1){1'b1}}};
    if (sat && range == RNG_BELOW) c_dout = {1'b1, {(DATA_W-1){1'b0}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;

endmodule

// File: rtl/tile_mac_engine.sv
// Tile MAC engine top: job FSM, i/j/k counters and SRAM address generation;
// arithmetic lives in tile_mac_unit.
module tile_mac_engine
  import tile_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 24,
  parameter int TILE   = 4,
  parameter int KMAX   = 16,
  parameter int ADDR_W = 10
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  input  logic [1:0]                 op,
  input  logic                       sat_mode,
  input  logic [$clog2(KMAX+1)-1:0]  k_len,
  input  logic [ADDR_W-1:0]          a_base,
  input  logic [ADDR_W-1:0]          b_base,
  input  logic [ADDR_W-1:0]          c_base,
  input  logic [ADDR_W-1:0]          stride,
  output logic [ADDR_W-1:0]          sram_a_addr,
  output logic [ADDR_W-1:0]          sram_b_addr,
  output logic                       sram_a_re,
  output logic                       sram_b_re,
  input  logic [DATA_W-1:0]          sram_a_dout,
  input  logic [DATA_W-1:0]          sram_b_dout,
  output logic [ADDR_W-1:0]          sram_c_addr,
  output logic                       sram_c_we,
  output logic [DATA_W-1:0]          sram_c_din,
  output logic                       busy,
  output logic                       done,
  output logic                       ovf
);

  localparam int KW   = $clog2(KMAX + 1);
  localparam int IJ_W = (TILE > 1) ? $clog2(TILE) : 1;

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic                sat_q, sat_d;
  logic [KW-1:0]       klen_q, klen_d;
  logic [ADDR_W-1:0]   a_base_q, a_base_d, b_base_q, b_base_d;
  logic [ADDR_W-1:0]   c_base_q, c_base_d, stride_q, stride_d;
  logic [IJ_W-1:0]     i_q, i_d, j_q, j_d;
  logic [KW-1:0]       k_q, k_d;

  logic                mac_clear, ovf_clear, wr_en;
  logic [KW-1:0]       k_eff;
  logic [DATA_W-1:0]   c_dout;
  logic [ADDR_W-1:0]   i_ext, j_ext, k_ext, row_i, row_k;

  assign k_eff = (op_q == OP_MUL) ? klen_q : KW'(1);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sat_d     = sat_q;
    klen_d    = klen_q;
    a_base_d  = a_base_q;
    b_base_d  = b_base_q;
    c_base_d  = c_base_q;
    stride_d  = stride_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    mac_clear = 1'b0;
    ovf_clear = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d      = op_e'(op);
          sat_d     = sat_mode;
          klen_d    = k_len;
          a_base_d  = a_base;
          b_base_d  = b_base;
          c_base_d  = c_base;
          stride_d  = stride;
          i_d       = '0;
          j_d       = '0;
          k_d       = '0;
          mac_clear = 1'b1;
          ovf_clear = 1'b1;
          // An invalid MUL depth skips straight to completion without touching SRAM.
          if (op_e'(op) == OP_MUL && (k_len == '0 || int'(k_len) > KMAX)) state_d = ST_DONE;
          else state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        k_d = k_q + KW'(1);
        if (k_q == k_eff - KW'(1)) begin
          k_d     = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_WRITE;
      ST_WRITE: begin
        wr_en     = 1'b1;
        mac_clear = 1'b1;
        state_d   = ST_RUN;
        if (j_q == IJ_W'(TILE - 1)) begin
          j_d = '0;
          if (i_q == IJ_W'(TILE - 1)) state_d = ST_DONE;
          else i_d = i_q + IJ_W'(1);
        end else begin
          j_d = j_q + IJ_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d   = ST_IDLE;
      mac_clear = 1'b1;
      ovf_clear = 1'b0;
      wr_en     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      sat_q    <= 1'b0;
      klen_q   <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
      c_base_q <= '0;
      stride_q <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sat_q    <= sat_d;
      klen_q   <= klen_d;
      a_base_q <= a_base_d;
      b_base_q <= b_base_d;
      c_base_q <= c_base_d;
      stride_q <= stride_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
    end
  end

  // Address products are taken at ADDR_W bits so every address wraps naturally.
  assign i_ext = ADDR_W'(i_q);
  assign j_ext = ADDR_W'(j_q);
  assign k_ext = ADDR_W'(k_q);
  assign row_i = i_ext * stride_q;
  assign row_k = k_ext * stride_q;

  always_comb begin
    sram_a_re   = 1'b0;
    sram_b_re   = 1'b0;
    sram_a_addr = '0;
    sram_b_addr = '0;
    sram_c_we   = 1'b0;
    sram_c_addr = '0;
    sram_c_din  = '0;
    if (state_q == ST_RUN) begin
      sram_a_re = 1'b1;
      sram_b_re = 1'b1;
      if (op_q == OP_MUL) begin
        sram_a_addr = a_base_q + row_i + k_ext;
        sram_b_addr = b_base_q + row_k + j_ext;
      end else begin
        sram_a_addr = a_base_q + row_i + j_ext;
        sram_b_addr = b_base_q + row_i + j_ext;
      end
    end
    if (state_q == ST_WRITE) begin
      sram_c_we   = 1'b1;
      sram_c_addr = c_base_q + row_i + j_ext;
      sram_c_din  = c_dout;
    end
  end

  assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_WRITE);
  assign done = (state_q == ST_DONE);

  tile_mac_unit #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue    (sram_a_re),
    .clear    (mac_clear),
    .abort    (abort),
    .wr_en    (wr_en),
    .ovf_clear(ovf_clear),
    .op       (op_q),
    .sat      (sat_q),
    .a_dout   (sram_a_dout),
    .b_dout   (sram_b_dout),
    .c_dout   (c_dout),
    .ovf      (ovf)
  );

endmodule

// File: tb/tb_tile_mac_engine.sv
// Scoreboard bench for tile_mac_engine: a plain-arithmetic tile model queues
// expected C writes per job; a negedge monitor pops and compares them.
module tb_tile_mac_engine;

  localparam int AW   = 10;
  localparam int MEMN = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0;
  logic [1:0]    op = '0;
  logic          sat_mode = 1'b0;
  logic [4:0]    k_len = '0;
  logic [AW-1:0] a_base = '0, b_base = '0, c_base = '0, stride = '0;
  logic [AW-1:0] sram_a_addr, sram_b_addr, sram_c_addr;
  logic          sram_a_re, sram_b_re, sram_c_we;
  logic [7:0]    sram_a_dout = '0, sram_b_dout = '0, sram_c_din;
  logic          busy, done, ovf;

  always #5 clk = ~clk;

  tile_mac_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .op(op),
    .sat_mode(sat_mode), .k_len(k_len), .a_base(a_base), .b_base(b_base),
    .c_base(c_base), .stride(stride), .sram_a_addr(sram_a_addr),
    .sram_b_addr(sram_b_addr), .sram_a_re(sram_a_re), .sram_b_re(sram_b_re),
    .sram_a_dout(sram_a_dout), .sram_b_dout(sram_b_dout),
    .sram_c_addr(sram_c_addr), .sram_c_we(sram_c_we), .sram_c_din(sram_c_din),
    .busy(busy), .done(done), .ovf(ovf)
  );

  logic [7:0] mem_a [MEMN];
  logic [7:0] mem_b [MEMN];

  always @(posedge clk) begin
    if (sram_a_re) sram_a_dout <= mem_a[sram_a_addr];
    if (sram_b_re) sram_b_dout <= mem_b[sram_b_addr];
  end

  typedef struct {int addr; int data;} wr_t;
  wr_t exp_q[$];
  int  ra_log[$];
  int  wr_count = 0;
  int  n_checks = 0, n_errors = 0;

  int cfg_op, cfg_sat, cfg_klen, cfg_a, cfg_b, cfg_c, cfg_s;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every C write is checked against the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && sram_a_re) ra_log.push_back(int'(sram_a_addr));
    if (rst_n && sram_c_we) begin
      wr_t e;
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", longint'(sram_c_addr), -1);
      end else begin
        e = exp_q.pop_front();
        $display("write #%0d addr=%0d data=%0d (exp addr=%0d data=%0d)",
                 wr_count, sram_c_addr, sram_c_din, e.addr, e.data);
        check("c_addr", longint'(sram_c_addr), longint'(e.addr));
        check("c_data", longint'(sram_c_din), longint'(e.data));
      end
    end
  end

  function automatic int rd(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  // Reference: for each output element compute the exact sum/difference/product,
  // then clamp or keep the low byte; queues the first `limit` writes.
  function automatic bit model(input int limit);
    bit ov = 1'b0;
    int kk;
    if (cfg_op == 0 && (cfg_klen < 1 || cfg_klen > 16)) return 1'b0;
    kk = (cfg_op == 0) ? cfg_klen : 1;
    for (int e = 0; e < 16 && e < limit; e++) begin
      int i = e / 4, j = e % 4, acc = 0, val;
      wr_t w;
      for (int k = 0; k < kk; k++) begin
        int a, b;
        if (cfg_op == 0) begin
          a = rd(mem_a[(cfg_a + i * cfg_s + k) % MEMN]);
          b = rd(mem_b[(cfg_b + k * cfg_s + j) % MEMN]);
        end else begin
          a = rd(mem_a[(cfg_a + i * cfg_s + j) % MEMN]);
          b = rd(mem_b[(cfg_b + i * cfg_s + j) % MEMN]);
        end
        case (cfg_op)
          1: acc = a + b;
          2: acc = a - b;
          default: acc = acc + a * b;
        endcase
      end
      val = acc;
      if (acc > 127) begin ov = 1'b1; if (cfg_sat != 0) val = 127; end
      if (acc < -128) begin ov = 1'b1; if (cfg_sat != 0) val = -128; end
      w.addr = (cfg_c + i * cfg_s + j) % MEMN;
      w.data = val & 255;
      exp_q.push_back(w);
    end
    return ov;
  endfunction

  task automatic set_cfg(input int o, s, kl, a, b, c, st);
    cfg_op = o; cfg_sat = s; cfg_klen = kl; cfg_a = a; cfg_b = b; cfg_c = c; cfg_s = st;
  endtask

  task automatic fill(input int av, input int bv, input bit rnd);
    for (int x = 0; x < MEMN; x++) begin
      mem_a[x] = rnd ? 8'($urandom) : 8'(av);
      mem_b[x] = rnd ? 8'($urandom) : 8'(bv);
    end
  endtask

  // Drives start for one cycle; returns at the first negedge after the start edge.
  task automatic kick();
    @(negedge clk);
    op = 2'(cfg_op); sat_mode = cfg_sat[0]; k_len = 5'(cfg_klen);
    a_base = AW'(cfg_a); b_base = AW'(cfg_b); c_base = AW'(cfg_c); stride = AW'(cfg_s);
    wr_count = 0;
    ra_log.delete();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_job(input string name);
    bit ov;
    int n, expn, kk;
    bit rej;
    rej  = (cfg_op == 0 && (cfg_klen < 1 || cfg_klen > 16));
    kk   = (cfg_op == 0) ? cfg_klen : 1;
    expn = rej ? 1 : 16 * (kk + 2) + 1;
    ov   = model(16);
    kick();
    n = 1;
    while (!done && n < 2000) begin
      @(negedge clk);
      n++;
    end
    $display("job %s op=%0d sat=%0d k=%0d: done after %0d cycles, writes=%0d, ovf=%0d",
             name, cfg_op, cfg_sat, cfg_klen, n, wr_count, ovf);
    check({name, "_done_cycle"}, n, expn);
    check({name, "_writes"}, wr_count, rej ? 0 : 16);
    check({name, "_ovf"}, longint'(ovf), longint'(ov));
    check({name, "_busy_at_done"}, longint'(busy), 0);
    check({name, "_queue_empty"}, exp_q.size(), 0);
    if (rej) check({name, "_no_reads"}, ra_log.size(), 0);
    @(negedge clk);
    check({name, "_done_pulse"}, longint'(done), 0);
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs_in_reset",
          longint'({busy, done, ovf, sram_a_re, sram_b_re, sram_c_we}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_outputs",
          longint'({busy, done, ovf, sram_a_re, sram_b_re, sram_c_we}), 0);

    fill(1, 2, 1'b0);
    set_cfg(0, 1, 16, 0, 64, 512, 16);     run_job("mul_ones");
    fill(100, 100, 1'b0);
    set_cfg(1, 1, 3, 10, 300, 700, 8);     run_job("add_sat");
    set_cfg(1, 0, 3, 10, 300, 700, 8);     run_job("add_trunc");
    fill(-128, 1, 1'b0);
    set_cfg(2, 1, 1, 0, 0, 100, 4);        run_job("sub_sat");
    fill(-3, 5, 1'b0);
    set_cfg(3, 1, 1, 0, 0, 100, 4);        run_job("had");

    // Address wrap: element (1,0) reads A at (1020 + 16) mod 1024
    fill(0, 0, 1'b1);
    set_cfg(1, 1, 1, 1020, 5, 40, 16);     run_job("wrap");
    check("wrap_row1_addr", (ra_log.size() > 4) ? ra_log[4] : -1, 12);

    set_cfg(0, 1, 0, 0, 0, 0, 4);          run_job("mul_k0");
    set_cfg(0, 0, 20, 0, 0, 0, 4);         run_job("mul_k20");

    for (int r = 0; r < 6; r++) begin
      fill(0, 0, 1'b1);
      set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
              int'($urandom_range(1, 16)), int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
              int'($urandom_range(0, 1023)));
      run_job($sformatf("rand%0d", r));
    end

    // Abort during RUN of element (1,2): six writes land, then nothing
    fill(100, 100, 1'b0);
    set_cfg(1, 1, 1, 0, 0, 200, 4);
    void'(model(6));
    kick();
    n = 0;
    while (!(wr_count == 6 && sram_a_re) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_elem6", longint'(n < 200), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_outputs",
          longint'({busy, done, sram_a_re, sram_b_re, sram_c_we}), 0);
    check("abort_ovf_kept", longint'(ovf), 1);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy || sram_c_we) n++;
    end
    $display("job abort: writes=%0d, activity after abort=%0d", wr_count, n);
    check("abort_quiet", n, 0);
    check("abort_writes", wr_count, 6);
    check("abort_queue_empty", exp_q.size(), 0);
    fill(-3, 5, 1'b0);
    set_cfg(3, 1, 1, 0, 0, 100, 4);        run_job("post_abort");

    // Asynchronous reset mid-job clears all outputs immediately
    fill(1, 1, 1'b0);
    set_cfg(0, 1, 16, 0, 0, 0, 4);
    kick();
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_job",
          longint'({busy, done, ovf, sram_a_re, sram_b_re, sram_c_we,
                    sram_a_addr, sram_b_addr, sram_c_addr, sram_c_din}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_stays_idle", longint'({busy, done, sram_a_re, sram_c_we}), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tile_mac_engine.md
# tile_mac_engine

Parametrised successor to the fixed 4x4 tile processor. It computes one TILE x TILE output tile per job, streaming operands straight from the A/B SRAMs and writing each result to the C SRAM, without buffering whole tiles. Supported operations are matrix multiply with runtime K depth, elementwise ADD, SUB and Hadamard product. Arithmetic is signed, with selectable saturation and a sticky overflow flag. It sits between the NPU job controller and the three scratch SRAMs.

## Interface
- DATA_W, 8: operand and result width, signed two's complement
- ACC_W, 24: accumulator width; must be at least 2*DATA_W + clog2(KMAX)
- TILE, 4: output tile dimension (TILE x TILE elements)
- KMAX, 16: maximum inner dimension for MUL
- ADDR_W, 10: SRAM address width; all address arithmetic wraps modulo 2^ADDR_W
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  job request; accepted only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE from any state
- op  in  2  0=MUL, 1=ADD, 2=SUB, 3=HAD; latched at start
- sat_mode  in  1  1=clamp output, 0=truncate to low DATA_W bits; latched at start
- k_len  in  clog2(KMAX+1)  MUL inner length, 1..KMAX; latched at start
- a_base, b_base, c_base, stride  in  ADDR_W each  base addresses and row stride; latched at start
- sram_a_addr, sram_b_addr  out  ADDR_W  read addresses
- sram_a_re, sram_b_re  out  1  read enables
- sram_a_dout, sram_b_dout  in  DATA_W  read data, valid exactly 1 cycle after re
- sram_c_addr  out  ADDR_W  write address
- sram_c_we  out  1  write enable
- sram_c_din  out  DATA_W  write data
- busy  out  1  high while a job is active
- done  out  1  single-cycle completion pulse
- ovf  out  1  sticky; set when any output falls outside the DATA_W signed range; cleared on accepted start

## Operation
- States: IDLE, RUN, DRAIN, WRITE, DONE. All registered outputs reset to 0.
- IDLE + start: latch the configuration, clear ovf, set i=j=k=0, clear acc, go to RUN.
- Effective K is k_len for MUL and 1 for ADD, SUB and HAD.
- RUN: assert re on A and B every cycle for k=0..K-1.
  - MUL addresses: A = a_base + i*stride + k; B = b_base + k*stride + j.
  - Elementwise addresses: A = a_base + i*stride + j; B = b_base + i*stride + j.
  - After the issue with k=K-1, go to DRAIN.
- Data from issue n is consumed in cycle n+1, tracked by a delayed valid flag:
  - MUL and HAD: acc += sext(a*b)
  - ADD: acc = sext(a) + sext(b)
  - SUB: acc = sext(a) - sext(b)
- DRAIN: the last operand pair is accumulated; no reads are issued.
- WRITE: sram_c_we=1, sram_c_addr = c_base + i*stride + j, sram_c_din = acc converted to DATA_W.
  - Conversion with sat_mode=1: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Conversion with sat_mode=0: take acc[DATA_W-1:0].
  - In either mode, an out-of-range acc sets ovf.
  - acc clears. Advance j, then i (row-major). If the element just written is the last, go to DONE; otherwise go to RUN with k=0.
- DONE: done=1 for one cycle, busy=0, go to IDLE.
- MUL with k_len=0 or k_len>KMAX is rejected: no SRAM access and no writes. The engine goes IDLE -> DONE, so done pulses 1 cycle after the start edge. ovf stays 0.
- start while busy is ignored.
- abort has priority over all else. Next cycle: IDLE, re=we=0, no done pulse, ovf keeps its value.
- start and abort in the same IDLE cycle: abort wins and the job is not accepted.

## Timing
- Per output element: K RUN cycles + 1 DRAIN cycle + 1 WRITE cycle.
- done is high TILE*TILE*(K+2)+1 cycles after the start edge. With defaults: MUL k_len=16 gives 289 cycles; elementwise gives 49 cycles.
- busy rises on the cycle after start is sampled and falls when done is high.
- Exactly TILE*TILE C writes per job, in row-major order.
- The read-to-use path is exactly 1 cycle; the SRAM must have no other latency.

## Structure
- Package tile_pkg: op enum (OP_MUL, OP_ADD, OP_SUB, OP_HAD), state enum, and a sat_conv function (acc to DATA_W plus overflow bit).
- Sub-module tile_mac_unit: holds the operand-valid pipeline flag, the multiplier/adder/subtractor, the ACC_W accumulator and the saturation logic. The top level keeps the FSM, counters and address generation.

## Test plan
- MUL: A all 1, B all 2, k_len=16, sat_mode=1 -> 16 writes of 32 at c_base+i*stride+j; done at cycle 289; ovf=0.
- ADD with A=100, B=100: sat_mode=1 -> every C=127 and ovf=1; sat_mode=0 -> every C=-56 (0xC8) and ovf=1.
- SUB A=-128, B=1 with sat_mode=1 -> C=-128 and ovf=1. HAD A=-3, B=5 -> C=-15 and ovf=0.
- Address wrap: a_base=1020, stride=16, ADDR_W=10 -> the second A row read starts at address 12.
- abort asserted mid-RUN of element (1,2) -> re/we low next cycle, no done, busy=0; a following job runs normally with ovf cleared.
- MUL with k_len=0 -> done 1 cycle after start, zero re/we activity. rst_n asserted mid-job -> all outputs 0 immediately.
